// File: rtl/pcoeff_result_collector_pkg.sv
// Shared widths and tree-sizing helpers for the pcoeff result collector.
package pcoeff_result_collector_pkg;

  localparam int DEFAULT_NUM_LANES        = 4;
  localparam int DEFAULT_LANE_SUM_WIDTH   = 48;
  localparam int DEFAULT_LANE_COUNT_WIDTH = 13;
  localparam int DEFAULT_FIFO_DEPTH_LOG2  = 2;
  localparam int DEFAULT_BATCH_IDX_WIDTH  = 16;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // One pairwise-add level per halving of the zero-padded lane set.
  function automatic int treeLevels(input int numLanes);
    return clog2(numLanes);
  endfunction

endpackage

// File: rtl/result_lane_fifo.sv
// Register-based per-lane FIFO; dataOut is valid combinationally while not empty.
module result_lane_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] dataIn,
  input  logic             pop,
  output logic [WIDTH-1:0] dataOut,
  output logic             empty,
  output logic             full
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wrPtr;
  logic [DEPTH_LOG2-1:0] rdPtr;
  logic [DEPTH_LOG2:0]   count;
  logic                  doPush;
  logic                  doPop;

  assign doPush  = push && !full;
  assign doPop   = pop && !empty;
  assign empty   = (count == '0);
  // count never exceeds DEPTH, so its top bit alone marks a full FIFO
  assign full    = count[DEPTH_LOG2];
  assign dataOut = mem[rdPtr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) begin
        mem[wrPtr] <= dataIn;
        wrPtr      <= wrPtr + 1'b1;
      end
      if (doPop) rdPtr <= rdPtr + 1'b1;
      if (doPush && !doPop) count <= count + 1'b1;
      else if (doPop && !doPush) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/pcoeff_result_collector.sv
// Buffers per-lane {sum,count} results and releases one combined result per batch
// through a registered, stallable adder tree with a valid/ready output.
module pcoeff_result_collector
  import pcoeff_result_collector_pkg::*;
#(
  parameter int NUM_LANES        = DEFAULT_NUM_LANES,
  parameter int LANE_SUM_WIDTH   = DEFAULT_LANE_SUM_WIDTH,
  parameter int LANE_COUNT_WIDTH = DEFAULT_LANE_COUNT_WIDTH,
  parameter int FIFO_DEPTH_LOG2  = DEFAULT_FIFO_DEPTH_LOG2,
  parameter int BATCH_IDX_WIDTH  = DEFAULT_BATCH_IDX_WIDTH
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic [NUM_LANES-1:0]                          laneValid,
  input  logic [NUM_LANES*LANE_SUM_WIDTH-1:0]           laneSum,
  input  logic [NUM_LANES*LANE_COUNT_WIDTH-1:0]         laneCount,
  output logic [NUM_LANES-1:0]                          laneReady,
  input  logic [NUM_LANES-1:0]                          laneMask,
  output logic                                          outValid,
  input  logic                                          outReady,
  output logic [LANE_SUM_WIDTH+clog2(NUM_LANES)-1:0]    outSum,
  output logic [LANE_COUNT_WIDTH+clog2(NUM_LANES)-1:0]  outCount,
  output logic [BATCH_IDX_WIDTH-1:0]                    outBatchIndex,
  output logic [NUM_LANES-1:0]                          laneOverflow
);

  localparam int TREE_LEVELS = treeLevels(NUM_LANES);
  localparam int PADDED      = 1 << TREE_LEVELS;
  localparam int OUT_SUM_W   = LANE_SUM_WIDTH + TREE_LEVELS;
  localparam int OUT_COUNT_W = LANE_COUNT_WIDTH + TREE_LEVELS;
  localparam int WORD_W      = LANE_SUM_WIDTH + LANE_COUNT_WIDTH;

  logic [NUM_LANES-1:0]   fifoEmpty;
  logic [NUM_LANES-1:0]   fifoFull;
  logic [NUM_LANES-1:0]   lanePop;
  logic [WORD_W-1:0]      fifoOut     [NUM_LANES];
  logic [OUT_SUM_W-1:0]   treeSumIn   [PADDED];
  logic [OUT_COUNT_W-1:0] treeCountIn [PADDED];
  logic                   advance;
  logic                   popFire;

  logic [OUT_SUM_W-1:0]   sumPipe   [TREE_LEVELS+1][PADDED];
  logic [OUT_COUNT_W-1:0] countPipe [TREE_LEVELS+1][PADDED];
  logic [TREE_LEVELS:0]   validPipe;

  // Masked lanes are neither waited on nor popped; an empty mask never fires.
  assign advance   = !outValid || outReady;
  assign popFire   = advance && (|laneMask) && ((fifoEmpty & laneMask) == '0);
  assign lanePop   = popFire ? laneMask : '0;
  assign laneReady = ~fifoFull;

  for (genvar i = 0; i < PADDED; i++) begin : gLane
    if (i < NUM_LANES) begin : gReal
      result_lane_fifo #(
        .WIDTH      (WORD_W),
        .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
      ) uFifo (
        .clk     (clk),
        .rst     (rst),
        .push    (laneValid[i] && laneReady[i]),
        .dataIn  ({laneCount[i*LANE_COUNT_WIDTH +: LANE_COUNT_WIDTH],
                   laneSum[i*LANE_SUM_WIDTH +: LANE_SUM_WIDTH]}),
        .pop     (lanePop[i]),
        .dataOut (fifoOut[i]),
        .empty   (fifoEmpty[i]),
        .full    (fifoFull[i])
      );
      assign treeSumIn[i]   = laneMask[i] ? OUT_SUM_W'(fifoOut[i][LANE_SUM_WIDTH-1:0]) : '0;
      assign treeCountIn[i] = laneMask[i] ? OUT_COUNT_W'(fifoOut[i][WORD_W-1:LANE_SUM_WIDTH]) : '0;
    end else begin : gPad
      assign treeSumIn[i]   = '0;
      assign treeCountIn[i] = '0;
    end
  end

  // Stage 0 captures the popped words; level k halves the operand set. Bubbles
  // hold along with real results whenever the output is stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      validPipe <= '0;
      for (int k = 0; k <= TREE_LEVELS; k++) begin
        for (int j = 0; j < PADDED; j++) begin
          sumPipe[k][j]   <= '0;
          countPipe[k][j] <= '0;
        end
      end
    end else if (advance) begin
      validPipe[0] <= popFire;
      for (int j = 0; j < PADDED; j++) begin
        sumPipe[0][j]   <= treeSumIn[j];
        countPipe[0][j] <= treeCountIn[j];
      end
      for (int k = 1; k <= TREE_LEVELS; k++) begin
        validPipe[k] <= validPipe[k-1];
        for (int j = 0; j < (PADDED >> k); j++) begin
          sumPipe[k][j]   <= sumPipe[k-1][2*j] + sumPipe[k-1][2*j+1];
          countPipe[k][j] <= countPipe[k-1][2*j] + countPipe[k-1][2*j+1];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      outValid      <= 1'b0;
      outSum        <= '0;
      outCount      <= '0;
      outBatchIndex <= '0;
      laneOverflow  <= '0;
    end else begin
      if (advance) begin
        outValid <= validPipe[TREE_LEVELS];
        outSum   <= sumPipe[TREE_LEVELS][0];
        outCount <= countPipe[TREE_LEVELS][0];
      end
      if (outValid && outReady) outBatchIndex <= outBatchIndex + 1'b1;
      laneOverflow <= laneOverflow | (laneValid & fifoFull);
    end
  end

endmodule
